pc_sequencer: RTL and testbench

Multi-cycle controller that owns the program-counter register's load strobe and next-value input. It runs fetch/execute/update sequencing and handshakes with instruction memory. It resolves the next PC from sequential, branch, jump and jump-register sources, and stops the core on halt, misaligned target or fetch timeout.

---
 rtl/pc_sequencer_pkg.sv | 38 +++
 rtl/pc_sequencer_next_pc_calc.sv | 38 +++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// word constants, jump-field bit positions and the redirect flag bundle.
package pc_sequencer_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned JADDR_W   = 26;
  localparam int unsigned TIMER_W   = 8;

  localparam logic [ADDR_W-1:0] WORD_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PC_INCR   = ADDR_W'(4);

  // Upper PC bits kept by an absolute jump.
  localparam int unsigned JMP_HI_MSB = 31;
  localparam int unsigned JMP_HI_LSB = 28;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Redirect flags presented by the execute stage, highest priority first.
  typedef struct packed {
    logic halt_req;
    logic jr;
    logic jmp;
    logic br_taken;
  } redirect_t;

  // Sign-extend a word offset and convert it to a byte offset.
  function automatic logic [ADDR_W-1:0] sext_word_off(input logic [IMM_W-1:0] imm);
    return {{(ADDR_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC resolution.
// Ports: pc_q (current PC), redir (redirect flags), imm16 (branch word
// offset), addr26 (jump field), rs_val (register target) -> target
// (selected next PC), is_halt (instruction is a halt).
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [ADDR_W-1:0]  pc_q,
  input  redirect_t          redir,
  input  logic [IMM_W-1:0]   imm16,
  input  logic [JADDR_W-1:0] addr26,
  input  logic [ADDR_W-1:0]  rs_val,
  output logic [ADDR_W-1:0]  target,
  output logic               is_halt
);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_target;

  assign pc4        = pc_q + PC_INCR;
  assign br_target  = pc4 + sext_word_off(imm16);
  assign jmp_target = {pc4[JMP_HI_MSB:JMP_HI_LSB], addr26, 2'b00};

  // Priority: halt > jr > jmp > branch > sequential. Target is unused on halt.
  always_comb begin
    target  = pc4;
    is_halt = redir.halt_req;
    if (redir.jr) begin
      target = rs_val;
    end else if (redir.jmp) begin
      target = jmp_target;
    end else if (redir.br_taken) begin
      target = br_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/update sequencer owning the PC load strobe and next value.
// Ports: clk, rst (async, active-high); pc_q (current PC); if_req/if_ack
// (instruction fetch handshake); ex_valid plus br_taken/imm16, jmp/addr26,
// jr/rs_val, halt_req (execute resolution); pc_next/pc_load (PC write);
// halted, misalign, fetch_err (sticky stop status).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_q,
  output logic               if_req,
  input  logic               if_ack,
  input  logic               ex_valid,
  input  logic               br_taken,
  input  logic [IMM_W-1:0]   imm16,
  input  logic               jmp,
  input  logic [JADDR_W-1:0] addr26,
  input  logic               jr,
  input  logic [ADDR_W-1:0]  rs_val,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_load,
  output logic               halted,
  output logic               misalign,
  output logic               fetch_err
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FETCH_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ADDR_W-1:0]  pc_next_q, pc_next_d;
  logic               if_req_q, if_req_d;
  logic               pc_load_q, pc_load_d;
  logic               halted_q, halted_d;
  logic               misalign_q, misalign_d;
  logic               fetch_err_q, fetch_err_d;

  redirect_t          redir;
  logic [ADDR_W-1:0]  target;
  logic               is_halt;

  assign redir = '{halt_req: halt_req, jr: jr, jmp: jmp, br_taken: br_taken};

  next_pc_calc u_next_pc_calc (
    .pc_q    (pc_q),
    .redir   (redir),
    .imm16   (imm16),
    .addr26  (addr26),
    .rs_val  (rs_val),
    .target  (target),
    .is_halt (is_halt)
  );

  // Next-state, timer, sticky flags and output decode from the next state.
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    pc_next_d   = pc_next_q;
    misalign_d  = misalign_q;
    fetch_err_d = fetch_err_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        // An ack arriving on the last allowed cycle still wins over timeout.
        if (if_ack) begin
          state_d = ST_EXEC;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = ST_HALT;
          fetch_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_EXEC: begin
        if (ex_valid) begin
          if (is_halt) begin
            state_d = ST_HALT;
          end else if (target[1:0] != 2'b00) begin
            state_d    = ST_HALT;
            misalign_d = 1'b1;
          end else begin
            pc_next_d = target;
            state_d   = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are flopped from the upcoming state so they align with it.
    if_req_d  = (state_d == ST_FETCH);
    pc_load_d = (state_d == ST_UPDATE);
    halted_d  = (state_d == ST_HALT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pc_next_q   <= WORD_ZERO;
      if_req_q    <= 1'b0;
      pc_load_q   <= 1'b0;
      halted_q    <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pc_next_q   <= pc_next_d;
      if_req_q    <= if_req_d;
      pc_load_q   <= pc_load_d;
      halted_q    <= halted_d;
      misalign_q  <= misalign_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign if_req    = if_req_q;
  assign pc_load   = pc_load_q;
  assign pc_next   = pc_next_q;
  assign halted    = halted_q;
  assign misalign  = misalign_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes the expected outcome
// of each instruction, a monitor pops and compares on pc_load / halt entry.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_q;
  logic        if_req, if_ack, ex_valid, br_taken, jmp, jr, halt_req;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic [31:0] rs_val, pc_next;
  logic        pc_load, halted, misalign, fetch_err;

  typedef struct {
    bit          is_load;
    logic [31:0] val;
    bit          mis;
    bit          fe;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_cur = 32'h0;
  logic [31:0] model_next = 32'h0;
  logic        prev_load = 1'b0;
  logic        prev_halt = 1'b0;

  pc_sequencer #(.FETCH_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .pc_q(pc_q), .if_req(if_req), .if_ack(if_ack),
    .ex_valid(ex_valid), .br_taken(br_taken), .imm16(imm16), .jmp(jmp),
    .addr26(addr26), .jr(jr), .rs_val(rs_val), .halt_req(halt_req),
    .pc_next(pc_next), .pc_load(pc_load), .halted(halted),
    .misalign(misalign), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  assign pc_q = pc_cur;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: outcome of one resolved instruction from the ISA rules.
  function automatic exp_t model(input logic [31:0] pc, input bit h, input bit rj,
                                 input bit j, input bit b, input logic [15:0] imm,
                                 input logic [25:0] a26, input logic [31:0] rs,
                                 input logic [31:0] cur_next);
    exp_t        r;
    logic [31:0] seq, t;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(imm)) * 4;
    r.val = cur_next;
    r.is_load = 1'b0;
    r.mis = 1'b0;
    r.fe = 1'b0;
    if (h) return r;
    if (rj)     t = rs;
    else if (j) t = (seq & 32'hF000_0000) | (32'(a26) * 32'd4);
    else if (b) t = seq + 32'(off);
    else        t = seq;
    if (t % 4 != 0) begin
      r.mis = 1'b1;
    end else begin
      r.is_load = 1'b1;
      r.val = t;
    end
    return r;
  endfunction

  task automatic clear_inputs();
    if_ack = 0; ex_valid = 0; br_taken = 0; jmp = 0; jr = 0; halt_req = 0;
    imm16 = 16'h0; addr26 = 26'h0; rs_val = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #1;
    sb.delete();
    model_next = 32'h0;
    pc_cur = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for if_req, returns number of negedges waited.
  task automatic wait_fetch(output int n);
    n = 0;
    while (!if_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!if_req) begin
      checks++;
      errors++;
      $display("FAIL fetch_wait: if_req got 0 expected 1 within 50 cycles");
    end
  endtask

  // One instruction: fetch handshake, execute resolution, push expectation.
  task automatic do_instr(input int ack_dly, input int exec_dly, input bit h, input bit rj,
                          input bit j, input bit b, input logic [15:0] imm,
                          input logic [25:0] a26, input logic [31:0] rs,
                          output int req_cycles);
    int   n;
    exp_t e;
    wait_fetch(n);
    req_cycles = 1;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      if (if_req) req_cycles++;
    end
    if_ack = 1'b1;
    @(negedge clk);
    if_ack = 1'b0;
    check("if_req_in_exec", 32'(if_req), 32'h0);
    for (int i = 0; i < exec_dly; i++) begin
      if_ack = 1'($urandom); br_taken = 1'($urandom); jmp = 1'($urandom);
      jr = 1'($urandom); halt_req = 1'($urandom); rs_val = $urandom | 32'h1;
      @(negedge clk);
    end
    if_ack = 1'b0;
    ex_valid = 1'b1;
    halt_req = h; jr = rj; jmp = j; br_taken = b;
    imm16 = imm; addr26 = a26; rs_val = rs;
    e = model(pc_cur, h, rj, j, b, imm, a26, rs, model_next);
    sb.push_back(e);
    if (e.is_load) model_next = e.val;
    @(negedge clk);
    clear_inputs();
    if (e.is_load) pc_cur = e.val;
  endtask

  // Monitor: compare against the scoreboard on each load or halt entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_load <= 1'b0;
      prev_halt <= 1'b0;
    end else begin
      if (pc_load) begin
        if (prev_load) check("pc_load_width", 32'(prev_load), 32'h0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: pc_load got 1 expected 0 (pc_next %h)", pc_next);
        end else begin
          e = sb.pop_front();
          check("load_kind", 32'(pc_load), 32'(e.is_load));
          check("pc_next", pc_next, e.val);
        end
      end
      if (halted && !prev_halt) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_halt: halted got 1 expected 0");
        end else begin
          e = sb.pop_front();
          check("halt_kind", 32'(e.is_load), 32'h0);
          check("halt_misalign", 32'(misalign), 32'(e.mis));
          check("halt_fetch_err", 32'(fetch_err), 32'(e.fe));
          check("halt_pc_next", pc_next, e.val);
        end
      end
      prev_load <= pc_load;
      prev_halt <= halted;
    end
  end

  initial begin
    int   rc, n, cnt;
    exp_t e;
    logic bad;
    rst = 1'b1;
    clear_inputs();
    #1;
    check("rst_pc_next", pc_next, 32'h0);
    check("rst_pc_load", 32'(pc_load), 32'h0);
    check("rst_if_req", 32'(if_req), 32'h0);
    check("rst_flags", {29'h0, halted, misalign, fetch_err}, 32'h0);
    do_reset();

    // Sequential from 0, ack on second FETCH cycle.
    do_instr(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, rc);
    check("seq_if_req_cycles", 32'(rc), 32'd2);
    check("seq_pc_next", pc_next, 32'h4);
    @(negedge clk);
    check("seq_load_drop", 32'(pc_load), 32'h0);
    check("seq_refetch", 32'(if_req), 32'h1);

    // Backward branch.
    pc_cur = 32'h100;
    do_instr(0, 1, 0, 0, 0, 1, 16'hFFFE, 26'h0, 32'h0, rc);
    check("branch_back", pc_next, 32'h0000_00FC);
    // Wrap.
    pc_cur = 32'hFFFF_FFFC;
    do_instr(2, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, rc);
    check("wrap", pc_next, 32'h0);
    // Jump beats branch; jr beats jump.
    pc_cur = 32'hF000_0010;
    do_instr(0, 0, 0, 0, 1, 1, 16'h0004, 26'h40, 32'h0, rc);
    check("jmp_over_br", pc_next, 32'hF000_0100);
    pc_cur = 32'hF000_0010;
    do_instr(0, 2, 0, 1, 1, 1, 16'h0004, 26'h40, 32'h200, rc);
    check("jr_over_jmp", pc_next, 32'h200);

    // Randomized aligned traffic.
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 3) == 0) pc_cur = $urandom & 32'hFFFF_FFFC;
      do_instr($urandom_range(0, 6), $urandom_range(0, 4), 0,
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0), 16'($urandom), 26'($urandom),
               $urandom & 32'hFFFF_FFFC, rc);
    end

    // Async reset while pc_load is high.
    do_instr(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, rc);
    check("pre_rst_load", 32'(pc_load), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_pc_load", 32'(pc_load), 32'h0);
    check("async_pc_next", pc_next, 32'h0);
    check("async_if_req", 32'(if_req), 32'h0);
    check("async_sb_empty", 32'(sb.size()), 32'h0);
    sb.delete();
    model_next = 32'h0;
    pc_cur = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    wait_fetch(n);
    check("rst_refetch_cycles", 32'(n), 32'd1);
    do_instr(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, rc);

    // Ack on the 15th FETCH cycle still succeeds.
    do_reset();
    pc_cur = 32'h40;
    do_instr(14, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, rc);
    check("ack15_if_req_cycles", 32'(rc), 32'd15);
    check("ack15_no_err", {30'h0, fetch_err, halted}, 32'h0);

    // Fetch timeout.
    do_reset();
    e.is_load = 1'b0; e.val = 32'h0; e.mis = 1'b0; e.fe = 1'b1;
    sb.push_back(e);
    wait_fetch(n);
    cnt = 0;
    for (int i = 0; i < 40 && if_req; i++) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_if_req_cycles", 32'(cnt), 32'd15);
    check("timeout_flags", {29'h0, halted, misalign, fetch_err}, 32'h5);

    // Halt instruction.
    do_reset();
    do_instr(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, rc);
    do_instr(0, 0, 1, 1, 0, 0, 16'h0, 26'h0, 32'h3, rc);
    check("halt_flags", {29'h0, halted, misalign, fetch_err}, 32'h4);

    // Misaligned jr, then inputs are ignored.
    do_reset();
    do_instr(1, 0, 0, 1, 0, 0, 16'h0, 26'h0, 32'h0000_0102, rc);
    check("mis_flags", {29'h0, halted, misalign, fetch_err}, 32'h6);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if_ack = 1'($urandom); ex_valid = 1'b1; jr = 1'($urandom);
      rs_val = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      bad = bad | pc_load | if_req | !halted | !misalign;
    end
    clear_inputs();
    check("mis_terminal", 32'(bad), 32'h0);
    check("mis_pc_next", pc_next, 32'h0);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
